ghost_dir_arbiter: RTL and testbench
====================================

GHOST_DIR_ARBITER -- requirements
Module: ghost_dir_arbiter

Interface
REQ-001 Parameter: SEED, 8'hA5, LFSR reset value; SEED SHALL be nonzero.
REQ-002 Clk  input  1  system clock (MAX10_CLK1_50 domain).
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 req  input  3  direction requests; bit0 red ghost, bit1 orange ghost, bit2 blue ghost.
REQ-005 mask_r, mask_o, mask_b  input  4 each  wall mask per ghost as {B,T,R,L}; 1 means blocked.
REQ-006 gnt  output  3  one-hot, one-cycle grant pulse to the served ghost.
REQ-007 dir  output  8  keycode-encoded direction, valid only while gnt is nonzero.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 Arbitration SHALL share one internal 8-bit LFSR among the three ghosts.
REQ-010 LFSR: Fibonacci, next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-011 The LFSR SHALL advance exactly once per grant, on the GRANT cycle, and at no other time.
REQ-012 Candidate index mapping: 0=L (8'h04), 1=R (8'h07), 2=T (8'h1A), 3=B (8'h16); no legal direction gives 8'h00.
REQ-013 The FSM SHALL have three states: IDLE, EVAL, GRANT.
REQ-014 IDLE: if req is nonzero, pick a ghost round-robin starting at rr_ptr, latch its mask, set cand = lfsr[1:0] and tries = 0, then go to EVAL.
REQ-015 EVAL, one candidate per cycle, in this order:
  - If cand is unblocked, latch dir and go to GRANT.
  - Otherwise cand = cand+1 mod 4 and tries+1.
  - After the 4th blocked candidate, latch dir = 8'h00 and go to GRANT.
REQ-016 GRANT: for one cycle, gnt[sel] = 1 and dir is driven; advance the LFSR; rr_ptr = sel+1 mod 3; go to IDLE.
REQ-017 Latency from req sampled in IDLE to gnt SHALL be 2 cycles plus the number of blocked candidates (range 2..6).
REQ-018 rr_ptr resets to 0 (red); simultaneous requests are served red, orange, blue, red, and so on.
REQ-019 Requesters SHALL hold req until gnt.
  - If req drops after selection, the grant is still issued.
  - A req bit already high in GRANT is not serviced until the next IDLE.
REQ-020 The mask is latched at selection; mask changes during EVAL SHALL be ignored.
REQ-021 Outside GRANT, gnt SHALL be 3'b000 and dir SHALL be 8'h00.

Reset
REQ-022 While Reset is high, at the Clk edge:
  - state = IDLE, lfsr = SEED, rr_ptr = 0.
  - gnt = 0, dir = 0, busy = 0.
  - Any last-direction registers are cleared.
REQ-023 Reset asserted during EVAL or GRANT SHALL abort the operation with no grant pulse.

Configuration
REQ-024 Macro GHOST_DIR_NO_REVERSE_EN.
REQ-025 When defined, the block SHALL keep a per-ghost last_dir register (reset 8'h00), updated on each non-zero grant.
REQ-026 When defined, EVAL SHALL also treat the reverse of last_dir as blocked: L/R and T/B are reverse pairs.
  - If no other candidate is open, the reverse direction SHALL be granted instead of 8'h00.
REQ-027 When not defined, no last_dir storage SHALL exist and only the mask blocks candidates.

Structure
REQ-028 Package pacman_pkg SHALL hold:
  - the direction keycode constants (DIR_L, DIR_R, DIR_T, DIR_B, DIR_NONE);
  - the ghost index enum;
  - the FSM state typedef;
  - the LFSR tap constant.
REQ-029 The LFSR SHALL be a sub-module, lfsr8_step, with ports Clk, Reset, step, and an 8-bit value output.

Verification
REQ-030 Reset, then req=001 with mask_r=0 -> gnt=001 two cycles later, dir=8'h07; LFSR becomes 8'h4A.
REQ-031 Reset, then req=111 held, all masks 0 -> grants in order 001, 010, 100 with dir 8'h07, 8'h1A, 8'h07 (LFSR 8'hA5, 8'h4A, 8'h95).
REQ-032 Reset, then req=001 with mask_r=4'b0010 -> R blocked, gnt at 3 cycles, dir=8'h1A.
REQ-033 Reset, then req=010 with mask_o=4'b1111 -> gnt=010 at 6 cycles, dir=8'h00; LFSR still advances to 8'h4A.
REQ-034 req=001, then Reset asserted on the 2nd EVAL cycle -> no gnt pulse, busy=0, and the next grant uses LFSR 8'hA5.
REQ-035 With GHOST_DIR_NO_REVERSE_EN: red last_dir=8'h07, LFSR cand=0 (L), mask 0 -> L skipped, dir=8'h07; with mask_r=4'b1110 -> dir=8'h04.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and constants for the ghost direction arbiter: keycodes,
// ghost indices, FSM states, LFSR taps and small helpers.
package pacman_pkg;

    localparam logic [7:0] DIR_L    = 8'h04;
    localparam logic [7:0] DIR_R    = 8'h07;
    localparam logic [7:0] DIR_T    = 8'h1A;
    localparam logic [7:0] DIR_B    = 8'h16;
    localparam logic [7:0] DIR_NONE = 8'h00;

    // Feedback taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        GHOST_RED    = 2'd0,
        GHOST_ORANGE = 2'd1,
        GHOST_BLUE   = 2'd2
    } ghost_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_GRANT
    } state_e;

    function automatic logic [7:0] idx_to_dir(input logic [1:0] idx);
        logic [7:0] d;
        case (idx)
            2'd0:    d = DIR_L;
            2'd1:    d = DIR_R;
            2'd2:    d = DIR_T;
            default: d = DIR_B;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] dir_to_idx(input logic [7:0] d);
        logic [1:0] idx;
        case (d)
            DIR_R:   idx = 2'd1;
            DIR_T:   idx = 2'd2;
            DIR_B:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic ghost_e next_ghost(input ghost_e g);
        ghost_e n;
        case (g)
            GHOST_RED:    n = GHOST_ORANGE;
            GHOST_ORANGE: n = GHOST_BLUE;
            default:      n = GHOST_RED;
        endcase
        return n;
    endfunction

    // First requesting ghost at or after ptr, wrapping red->orange->blue.
    function automatic ghost_e rr_pick(input logic [2:0] req, input ghost_e ptr);
        ghost_e g0;
        ghost_e g1;
        ghost_e g2;
        ghost_e pick;
        g0 = ptr;
        g1 = next_ghost(g0);
        g2 = next_ghost(g1);
        if (req[g0])      pick = g0;
        else if (req[g1]) pick = g1;
        else              pick = g2;
        return pick;
    endfunction

endpackage

// File: rtl/lfsr8_step.sv
// 8-bit Fibonacci LFSR that advances only when step is high.
module lfsr8_step
    import pacman_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       step,
    output logic [7:0] value
);

    logic [7:0] r_value;

    always_ff @(posedge Clk) begin
        if (Reset)
            r_value <= SEED;
        else if (step)
            r_value <= {r_value[6:0], ^(r_value & LFSR_TAPS)};
    end

    assign value = r_value;

endmodule

// File: rtl/ghost_dir_arbiter.sv
// Round-robin arbiter handing each ghost a random open direction from a shared LFSR.
// Optional macro GHOST_DIR_NO_REVERSE_EN forbids reversing the last granted direction.
module ghost_dir_arbiter
    import pacman_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] req,
    input  logic [3:0] mask_r,
    input  logic [3:0] mask_o,
    input  logic [3:0] mask_b,
    output logic [2:0] gnt,
    output logic [7:0] dir,
    output logic       busy
);

    state_e     r_state;
    ghost_e     r_sel;
    ghost_e     r_rr_ptr;
    logic [3:0] r_mask;
    logic [1:0] r_cand;
    logic [2:0] r_tries;
    logic [2:0] r_gnt;
    logic [7:0] r_dir;
    logic       r_busy;

    logic [7:0] w_lfsr;
    logic       w_step;
    ghost_e     w_sel;
    logic [3:0] w_mask_sel;
    logic       w_blocked;
    logic [7:0] w_fallback_dir;
    logic       w_unused_lfsr;

    assign w_step        = (r_state == ST_GRANT);
    assign w_unused_lfsr = ^w_lfsr[7:2];

    lfsr8_step #(
        .SEED (SEED)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .step  (w_step),
        .value (w_lfsr)
    );

    assign w_sel = rr_pick(req, r_rr_ptr);

    always_comb begin
        w_mask_sel = mask_r;
        case (w_sel)
            GHOST_ORANGE: w_mask_sel = mask_o;
            GHOST_BLUE:   w_mask_sel = mask_b;
            default:      w_mask_sel = mask_r;
        endcase
    end

`ifdef GHOST_DIR_NO_REVERSE_EN
    logic [7:0] r_last_r;
    logic [7:0] r_last_o;
    logic [7:0] r_last_b;
    logic [7:0] w_last_sel;
    logic       w_rev_valid;
    logic [1:0] w_rev_idx;

    always_comb begin
        w_last_sel = r_last_r;
        case (r_sel)
            GHOST_ORANGE: w_last_sel = r_last_o;
            GHOST_BLUE:   w_last_sel = r_last_b;
            default:      w_last_sel = r_last_r;
        endcase
    end

    // Reverse pairs are L/R and T/B, i.e. candidate index with bit 0 flipped.
    assign w_rev_valid    = (w_last_sel != DIR_NONE);
    assign w_rev_idx      = dir_to_idx(w_last_sel) ^ 2'b01;
    assign w_blocked      = r_mask[r_cand] | (w_rev_valid && (r_cand == w_rev_idx));
    assign w_fallback_dir = (w_rev_valid && !r_mask[w_rev_idx]) ? idx_to_dir(w_rev_idx) : DIR_NONE;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last_r <= DIR_NONE;
            r_last_o <= DIR_NONE;
            r_last_b <= DIR_NONE;
        end else if (r_state == ST_GRANT && r_dir != DIR_NONE) begin
            case (r_sel)
                GHOST_ORANGE: r_last_o <= r_dir;
                GHOST_BLUE:   r_last_b <= r_dir;
                default:      r_last_r <= r_dir;
            endcase
        end
    end
`else
    assign w_blocked      = r_mask[r_cand];
    assign w_fallback_dir = DIR_NONE;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_sel    <= GHOST_RED;
            r_rr_ptr <= GHOST_RED;
            r_mask   <= '0;
            r_cand   <= '0;
            r_tries  <= '0;
            r_gnt    <= '0;
            r_dir    <= DIR_NONE;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_gnt <= '0;
                    r_dir <= DIR_NONE;
                    if (|req) begin
                        r_sel   <= w_sel;
                        r_mask  <= w_mask_sel;
                        r_cand  <= w_lfsr[1:0];
                        r_tries <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    // tries==4 only after every candidate was seen blocked.
                    if (r_tries == 3'd4) begin
                        r_dir   <= w_fallback_dir;
                        r_gnt   <= 3'b001 << r_sel;
                        r_state <= ST_GRANT;
                    end else if (!w_blocked) begin
                        r_dir   <= idx_to_dir(r_cand);
                        r_gnt   <= 3'b001 << r_sel;
                        r_state <= ST_GRANT;
                    end else begin
                        r_cand  <= r_cand + 2'd1;
                        r_tries <= r_tries + 3'd1;
                    end
                end
                ST_GRANT: begin
                    r_gnt    <= '0;
                    r_dir    <= DIR_NONE;
                    r_rr_ptr <= next_ghost(r_sel);
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_dir   <= DIR_NONE;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reset during GRANT must suppress the pulse already sitting in the register.
    assign gnt  = Reset ? 3'b000   : r_gnt;
    assign dir  = Reset ? DIR_NONE : r_dir;
    assign busy = r_busy;

endmodule

// File: tb/tb_ghost_dir_arbiter.sv
// Directed self-checking bench for ghost_dir_arbiter; expectations hand-derived
// from the LFSR sequence A5, 4A, 95, 2A, 54, A9.
module tb_ghost_dir_arbiter;

    logic       Clk;
    logic       Reset;
    logic [2:0] req;
    logic [3:0] mask_r;
    logic [3:0] mask_o;
    logic [3:0] mask_b;
    logic [2:0] gnt;
    logic [7:0] dir;
    logic       busy;

    int n_total;
    int n_pass;
    int n_fail;

    ghost_dir_arbiter #(
        .SEED (8'hA5)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    (req),
        .mask_r (mask_r),
        .mask_o (mask_o),
        .mask_b (mask_b),
        .gnt    (gnt),
        .dir    (dir),
        .busy   (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        req    = '0;
        mask_r = '0;
        mask_o = '0;
        mask_b = '0;
        @(negedge Clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_dir", 32'(dir), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        Reset = 1'b0;
    endtask

    // Called at a negedge; latency counts rising edges until gnt is seen.
    task automatic do_grant(input string tag, input logic [2:0] r,
                            input logic [3:0] mr, input logic [3:0] mo, input logic [3:0] mb,
                            input bit hold, input logic [2:0] egnt, input logic [7:0] edir,
                            input int elat);
        int  n;
        bit  got;
        req    = r;
        mask_r = mr;
        mask_o = mo;
        mask_b = mb;
        n      = 0;
        got    = 1'b0;
        while (!got && n < 10) begin
            @(negedge Clk);
            n++;
            if (gnt !== 3'b000) got = 1'b1;
            else if (n == elat - 1) chk({tag, "_busy"}, 32'(busy), 32'h1);
        end
        chk({tag, "_lat"}, 32'(n), 32'(elat));
        chk({tag, "_gnt"}, 32'(gnt), 32'(egnt));
        chk({tag, "_dir"}, 32'(dir), 32'(edir));
        if (!hold) begin
            req = '0;
            @(negedge Clk);
            chk({tag, "_idle_gnt"}, 32'(gnt), 32'h0);
            chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        Reset   = 1'b1;
        req     = '0;
        mask_r  = '0;
        mask_o  = '0;
        mask_b  = '0;
        repeat (2) @(negedge Clk);

        // Single red request, then a second one to see the LFSR moved to 4A.
        do_reset();
        do_grant("red_first", 3'b001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b001, 8'h07, 2);
        do_grant("red_second", 3'b001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b001, 8'h1A, 2);

        // All three held: red, orange, blue in turn.
        do_reset();
        do_grant("rr_red", 3'b111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b001, 8'h07, 2);
        do_grant("rr_orange", 3'b111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b010, 8'h1A, 3);
        do_grant("rr_blue", 3'b111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b100, 8'h07, 3);

        // R blocked: one extra evaluation cycle, T granted.
        do_reset();
        do_grant("one_blocked", 3'b001, 4'b0010, 4'b0000, 4'b0000, 1'b0, 3'b001, 8'h1A, 3);

        // Fully walled orange: grant of 8'h00, LFSR still advances.
        do_reset();
        do_grant("all_blocked", 3'b010, 4'b0000, 4'b1111, 4'b0000, 1'b0, 3'b010, 8'h00, 6);
        do_grant("after_blocked", 3'b010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b010, 8'h1A, 2);

        // Reset in the second EVAL cycle aborts with no pulse and restores the seed.
        do_reset();
        req    = 3'b001;
        mask_r = 4'b0010;
        @(negedge Clk);
        chk("abort_eval1_busy", 32'(busy), 32'h1);
        chk("abort_eval1_gnt", 32'(gnt), 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        req   = '0;
        @(negedge Clk);
        chk("abort_gnt", 32'(gnt), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        Reset  = 1'b0;
        mask_r = '0;
        repeat (3) @(negedge Clk);
        chk("abort_quiet_gnt", 32'(gnt), 32'h0);
        do_grant("abort_regrant", 3'b001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b001, 8'h07, 2);

        // Blue request dropped and mask slammed shut after selection: still granted T.
        req    = 3'b100;
        mask_b = 4'b0000;
        @(negedge Clk);
        chk("drop_busy", 32'(busy), 32'h1);
        req    = '0;
        mask_b = 4'b1111;
        @(negedge Clk);
        chk("drop_gnt", 32'(gnt), 32'h4);
        chk("drop_dir", 32'(dir), 32'h1A);
        @(negedge Clk);
        chk("drop_idle_gnt", 32'(gnt), 32'h0);
        mask_b = '0;

        // Pointer now red: orange beats blue, then blue beats red.
        do_grant("ptr_orange", 3'b110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b010, 8'h07, 2);
        do_grant("ptr_blue", 3'b101, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b100, 8'h1A, 2);

        // LFSR 54 (cand L) then A9 (cand R) with only L open.
`ifdef GHOST_DIR_NO_REVERSE_EN
        do_grant("rev_skip", 3'b001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b001, 8'h07, 3);
        do_grant("rev_forced", 3'b001, 4'b1110, 4'b0000, 4'b0000, 1'b0, 3'b001, 8'h04, 6);
`else
        do_grant("cand_left", 3'b001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b001, 8'h04, 2);
        do_grant("wrap_left", 3'b001, 4'b1110, 4'b0000, 4'b0000, 1'b0, 3'b001, 8'h04, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
